// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM block: mode encodings,
// default timing constants and the SERVO threshold mapping.
package pwm_pkg;

  typedef logic pwm_mode_t;

  localparam pwm_mode_t MODE_DIRECT = 1'b0;
  localparam pwm_mode_t MODE_SERVO  = 1'b1;

  localparam int unsigned DEF_NUM_CH     = 3;
  localparam int unsigned DEF_CNT_W      = 8;
  localparam int unsigned DEF_PERIOD_TOP = 255;
  localparam int unsigned DEF_PRE_W      = 32;
  localparam int unsigned DEF_DIV_DIRECT = 10416;
  localparam int unsigned DEF_DIV_SERVO  = 200000;
  localparam int unsigned DEF_SERVO_MIN  = 13;
  localparam int unsigned DEF_SERVO_SPAN = 13;

  // Maps a duty value into the SERVO window. The product is formed at full
  // 64-bit width so nothing is lost before the shift.
  function automatic logic [63:0] servo_thr(
    input logic [63:0] duty,
    input int unsigned min_cnt,
    input int unsigned span_cnt,
    input int unsigned cnt_w
  );
    logic [63:0] w_prod;
    w_prod = duty * 64'(span_cnt);
    return 64'(min_cnt) + (w_prod >> cnt_w);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Prescaler for the PWM period counter: divides clk_i down to a tick whose
// interval depends on the active mode.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int unsigned PRE_W      = DEF_PRE_W,
  parameter int unsigned DIV_DIRECT = DEF_DIV_DIRECT,
  parameter int unsigned DIV_SERVO  = DEF_DIV_SERVO
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      en_i,
  input  pwm_mode_t mode_i,
  input  logic      clr_i,
  output logic      tick_o
);

  localparam logic [PRE_W-1:0] DIV_D = PRE_W'(DIV_DIRECT);
  localparam logic [PRE_W-1:0] DIV_S = PRE_W'(DIV_SERVO);

  logic [PRE_W-1:0] r_pre_cnt;
  logic [PRE_W-1:0] w_div;

  assign w_div  = (mode_i == MODE_SERVO) ? DIV_S : DIV_D;
  assign tick_o = en_i && (r_pre_cnt == w_div);

  // NOTE: clocked state uses <= so every flop updates from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pre_cnt <= '0;
    end else if (clr_i || tick_o) begin
      r_pre_cnt <= '0;
    end else if (en_i) begin
      r_pre_cnt <= r_pre_cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/pwm_multi_ch.sv
// N-channel PWM generator with double-buffered duty registers that are
// applied only at period wraps, per-channel enable/polarity and DIRECT/SERVO modes.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned PERIOD_TOP = DEF_PERIOD_TOP,
  parameter int unsigned PRE_W      = DEF_PRE_W,
  parameter int unsigned DIV_DIRECT = DEF_DIV_DIRECT,
  parameter int unsigned DIV_SERVO  = DEF_DIV_SERVO,
  parameter int unsigned SERVO_MIN  = DEF_SERVO_MIN,
  parameter int unsigned SERVO_SPAN = DEF_SERVO_SPAN,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              mode_i,
  input  logic              wr_en_i,
  input  logic [CH_W-1:0]   wr_ch_i,
  input  logic [CNT_W-1:0]  wr_duty_i,
  input  logic [NUM_CH-1:0] ch_en_i,
  input  logic [NUM_CH-1:0] pol_i,
  output logic [NUM_CH-1:0] pwm_o,
  output logic              period_o,
  output logic [NUM_CH-1:0] pend_o
);

  localparam logic [CNT_W-1:0] P_TOP = CNT_W'(PERIOD_TOP);

  logic             w_tick;
  logic             w_wrap;
  logic             w_mode_chg;
  logic [CNT_W-1:0] r_p_cnt;
  logic             r_period;
  pwm_mode_t        r_mode;

  pwm_prescaler #(
    .PRE_W      (PRE_W),
    .DIV_DIRECT (DIV_DIRECT),
    .DIV_SERVO  (DIV_SERVO)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (en_i),
    .mode_i (r_mode),
    .clr_i  (w_mode_chg),
    .tick_o (w_tick)
  );

  assign w_wrap     = w_tick && (r_p_cnt == P_TOP);
  assign w_mode_chg = w_wrap && (mode_i != r_mode);

  // The requested mode only becomes active at a wrap, like the duty values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_p_cnt  <= '0;
      r_period <= 1'b0;
      r_mode   <= MODE_DIRECT;
    end else begin
      r_period <= w_wrap;
      if (w_wrap) begin
        r_p_cnt <= '0;
        r_mode  <= mode_i;
      end else if (w_tick) begin
        r_p_cnt <= r_p_cnt + CNT_W'(1);
      end
    end
  end

  assign period_o = r_period;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] r_shadow;
    logic [CNT_W-1:0] r_active;
    logic             r_pend;
    logic             r_pwm;
    logic             w_wr_hit;
    logic [63:0]      w_thr;
    logic             w_below;

    assign w_wr_hit = wr_en_i && (wr_ch_i == CH_W'(gi));
    assign w_thr    = (r_mode == MODE_SERVO)
                    ? servo_thr(64'(r_active), SERVO_MIN, SERVO_SPAN, CNT_W)
                    : 64'(r_active);
    assign w_below  = 64'(r_p_cnt) < w_thr;

    // NOTE: the duty registers are plain flops, so they are reset to drop
    // any pending write together with the rest of the channel state.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_shadow <= '0;
        r_active <= '0;
        r_pend   <= 1'b0;
        r_pwm    <= 1'b0;
      end else begin
        if (w_wrap && r_pend) begin
          r_active <= r_shadow;
        end
        // A write on the wrap edge re-arms pending for the following period.
        if (w_wr_hit) begin
          r_shadow <= wr_duty_i;
          r_pend   <= 1'b1;
        end else if (w_wrap) begin
          r_pend   <= 1'b0;
        end
        r_pwm <= ch_en_i[gi] ? (w_below ^ pol_i[gi]) : pol_i[gi];
      end
    end

    assign pwm_o[gi]  = r_pwm;
    assign pend_o[gi] = r_pend;
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Self-checking bench for pwm_multi_ch: directed scenarios plus a randomized
// run compared against a behavioural model of the channel rules.
module tb_pwm_multi_ch;

  localparam int NCH   = 3;
  localparam int CW    = 4;
  localparam int TOP   = 15;
  localparam int DIVD  = 3;
  localparam int DIVS  = 7;
  localparam int SMIN  = 2;
  localparam int SSPAN = 2;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       en_i;
  logic       mode_i;
  logic       wr_en_i;
  logic [1:0] wr_ch_i;
  logic [3:0] wr_duty_i;
  logic [2:0] ch_en_i;
  logic [2:0] pol_i;
  logic [2:0] pwm_o;
  logic       period_o;
  logic [2:0] pend_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int       m_pre, m_p, m_mode;
  int       m_sh [NCH];
  int       m_act[NCH];
  bit [2:0] m_pend, m_pwm;
  bit       m_per;

  pwm_multi_ch #(
    .NUM_CH     (NCH),
    .CNT_W      (CW),
    .PERIOD_TOP (TOP),
    .PRE_W      (32),
    .DIV_DIRECT (DIVD),
    .DIV_SERVO  (DIVS),
    .SERVO_MIN  (SMIN),
    .SERVO_SPAN (SSPAN)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .mode_i    (mode_i),
    .wr_en_i   (wr_en_i),
    .wr_ch_i   (wr_ch_i),
    .wr_duty_i (wr_duty_i),
    .ch_en_i   (ch_en_i),
    .pol_i     (pol_i),
    .pwm_o     (pwm_o),
    .period_o  (period_o),
    .pend_o    (pend_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance the model by one clock using the current inputs, then let the
  // DUT take the same edge; returns on the following falling edge.
  task automatic adv();
    int       div, thr;
    bit       tick, wrap;
    bit [2:0] n_pwm;
    if (rst_i) begin
      m_pre = 0; m_p = 0; m_mode = 0; m_pwm = '0; m_per = 1'b0; m_pend = '0;
      for (int i = 0; i < NCH; i++) begin
        m_sh[i] = 0; m_act[i] = 0;
      end
    end else begin
      div  = m_mode ? DIVS : DIVD;
      tick = en_i && (m_pre == div);
      wrap = tick && (m_p == TOP);
      for (int i = 0; i < NCH; i++) begin
        thr = m_mode ? SMIN + (m_act[i] * SSPAN) / (1 << CW) : m_act[i];
        n_pwm[i] = ch_en_i[i] ? ((m_p < thr) != pol_i[i]) : pol_i[i];
      end
      m_pwm = n_pwm;
      m_per = wrap;
      if (tick || (wrap && mode_i != m_mode)) m_pre = 0;
      else if (en_i) m_pre = m_pre + 1;
      if (tick) m_p = wrap ? 0 : m_p + 1;
      if (wrap) begin
        for (int i = 0; i < NCH; i++) begin
          if (m_pend[i]) begin
            m_act[i]  = m_sh[i];
            m_pend[i] = 1'b0;
          end
        end
        m_mode = mode_i;
      end
      if (wr_en_i && wr_ch_i < NCH) begin
        m_sh[wr_ch_i]   = wr_duty_i;
        m_pend[wr_ch_i] = 1'b1;
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic write_duty(input int ch, input int duty);
    wr_en_i   = 1'b1;
    wr_ch_i   = 2'(ch);
    wr_duty_i = 4'(duty);
    adv();
    wr_en_i   = 1'b0;
  endtask

  task automatic wait_pulse(output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    for (int k = 0; k < 400; k++) begin
      adv();
      cycles++;
      if (period_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    for (int k = 0; k < n; k++) begin
      adv();
      if (pwm_o[ch] === 1'b1) hi++;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; en_i = 1'b0; mode_i = 1'b0; wr_en_i = 1'b0;
    wr_ch_i = '0; wr_duty_i = '0; ch_en_i = 3'b111; pol_i = 3'b000;
    for (int k = 0; k < 3; k++) begin
      adv();
      n_tests++;
      if ({pwm_o, period_o, pend_o} !== 7'b0) begin
        n_fail++;
        $display("FAIL reset cyc%0d pwm=%b period=%b pend=%b expected all 0", k, pwm_o, period_o, pend_o);
      end
    end
    rst_i = 1'b0;
  endtask

  task automatic test_idle();
    int last = -1;
    int npulse = 0;
    en_i = 1'b1;
    for (int k = 0; k < 200; k++) begin
      adv();
      n_tests++;
      if (pwm_o !== 3'b000 || pend_o !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_out cyc%0d pwm=%b pend=%b expected 000/000", k, pwm_o, pend_o);
      end
      if (period_o === 1'b1) begin
        npulse++;
        if (last >= 0) begin
          n_tests++;
          if (k - last != (DIVD + 1) * (TOP + 1)) begin
            n_fail++;
            $display("FAIL idle_interval got %0d expected %0d", k - last, (DIVD + 1) * (TOP + 1));
          end
        end
        last = k;
      end
    end
    n_tests++;
    if (npulse != 200 / ((DIVD + 1) * (TOP + 1))) begin
      n_fail++;
      $display("FAIL idle_pulses got %0d expected %0d", npulse, 200 / ((DIVD + 1) * (TOP + 1)));
    end
  endtask

  task automatic test_duty_apply();
    int hi;
    bit seen = 1'b0;
    for (int k = 0; k < 100 && m_p != 5; k++) adv();
    write_duty(1, 4);
    n_tests++;
    if (pend_o[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL apply_pend got %b expected 1", pend_o[1]);
    end
    for (int k = 0; k < 100; k++) begin
      adv();
      if (period_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      n_tests++;
      if (pwm_o[1] !== 1'b0 || pend_o[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL apply_early pwm1=%b pend1=%b expected 0/1", pwm_o[1], pend_o[1]);
      end
    end
    n_tests++;
    if (!seen || pend_o[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL apply_wrap seen=%b pend1=%b expected 1/0", seen, pend_o[1]);
    end
    count_high(1, 64, hi);
    n_tests++;
    if (hi != 4 * (DIVD + 1)) begin
      n_fail++;
      $display("FAIL apply_high got %0d expected %0d", hi, 4 * (DIVD + 1));
    end
  endtask

  task automatic test_write_on_wrap();
    int hi;
    for (int k = 0; k < 100 && !(m_p == TOP && m_pre == DIVD); k++) adv();
    write_duty(0, 8);
    n_tests++;
    if (period_o !== 1'b1 || pend_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL wow_edge period=%b pend0=%b expected 1/1", period_o, pend_o[0]);
    end
    count_high(0, 64, hi);
    n_tests++;
    if (hi != 0) begin
      n_fail++;
      $display("FAIL wow_old got %0d expected 0", hi);
    end
    n_tests++;
    if (period_o !== 1'b1 || pend_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL wow_apply period=%b pend0=%b expected 1/0", period_o, pend_o[0]);
    end
    count_high(0, 64, hi);
    n_tests++;
    if (hi != 8 * (DIVD + 1)) begin
      n_fail++;
      $display("FAIL wow_new got %0d expected %0d", hi, 8 * (DIVD + 1));
    end
  endtask

  task automatic test_extremes_polarity();
    int duties[5];
    bit pols[5];
    int hi, cyc, act, exp_hi;
    bit ok;
    duties = '{0, 0, 15, 15, 0};
    pols   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    duties[4] = $urandom_range(1, 14);
    pols[4]   = 1'($urandom_range(0, 1));
    for (int s = 0; s < 5; s++) begin
      pol_i[2] = pols[s];
      write_duty(2, duties[s]);
      wait_pulse(cyc, ok);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL ext_timeout scen%0d no period pulse", s);
      end
      count_high(2, 64, hi);
      act    = duties[s] * (DIVD + 1);
      exp_hi = pols[s] ? 64 - act : act;
      n_tests++;
      if (hi != exp_hi) begin
        n_fail++;
        $display("FAIL ext_high scen%0d duty=%0d pol=%0d got %0d expected %0d", s, duties[s], pols[s], hi, exp_hi);
      end
    end
  endtask

  task automatic test_servo();
    int cyc, len, hi;
    bit ok;
    mode_i = 1'b1;
    write_duty(1, 8);
    wait_pulse(cyc, ok);
    n_tests++;
    if (!ok || cyc > 64) begin
      n_fail++;
      $display("FAIL servo_switch ok=%b cycles=%0d expected <=64", ok, cyc);
    end
    len = 0; hi = 0;
    for (int k = 0; k < 400; k++) begin
      adv();
      len++;
      if (pwm_o[1] === 1'b1) hi++;
      if (period_o === 1'b1) break;
    end
    n_tests++;
    if (len != (DIVS + 1) * (TOP + 1)) begin
      n_fail++;
      $display("FAIL servo_period got %0d expected %0d", len, (DIVS + 1) * (TOP + 1));
    end
    n_tests++;
    if (hi != (SMIN + (8 * SSPAN) / 16) * (DIVS + 1)) begin
      n_fail++;
      $display("FAIL servo_high got %0d expected %0d", hi, (SMIN + (8 * SSPAN) / 16) * (DIVS + 1));
    end
  endtask

  task automatic test_invalid_freeze_reset();
    int cyc, exp_cyc, div;
    bit ok;
    bit seen_pulse = 1'b0;
    write_duty(3, 9);
    n_tests++;
    if (pend_o !== 3'b000) begin
      n_fail++;
      $display("FAIL invalid_ch pend=%b expected 000", pend_o);
    end
    en_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      adv();
      if (period_o === 1'b1) seen_pulse = 1'b1;
      n_tests++;
      if (pwm_o !== m_pwm) begin
        n_fail++;
        $display("FAIL freeze_pwm cyc%0d got %b expected %b", k, pwm_o, m_pwm);
      end
    end
    n_tests++;
    if (seen_pulse) begin
      n_fail++;
      $display("FAIL freeze_period got pulse expected none");
    end
    en_i = 1'b1;
    div = m_mode ? DIVS : DIVD;
    exp_cyc = (div - m_pre + 1) + (TOP - m_p) * (div + 1);
    wait_pulse(cyc, ok);
    n_tests++;
    if (!ok || cyc != exp_cyc) begin
      n_fail++;
      $display("FAIL resume_wrap ok=%b got %0d expected %0d", ok, cyc, exp_cyc);
    end
    for (int k = 0; k < 40; k++) adv();
    rst_i = 1'b1;
    adv();
    n_tests++;
    if ({pwm_o, period_o, pend_o} !== 7'b0) begin
      n_fail++;
      $display("FAIL midreset pwm=%b period=%b pend=%b expected all 0", pwm_o, period_o, pend_o);
    end
    rst_i = 1'b0;
    wait_pulse(cyc, ok);
    n_tests++;
    if (!ok || cyc != (DIVD + 1) * (TOP + 1)) begin
      n_fail++;
      $display("FAIL reset_mode ok=%b got %0d expected %0d", ok, cyc, (DIVD + 1) * (TOP + 1));
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      rst_i     = ($urandom_range(0, 299) == 0);
      en_i      = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 63) == 0) mode_i = ~mode_i;
      wr_en_i   = 1'($urandom_range(0, 1));
      wr_ch_i   = 2'($urandom_range(0, 3));
      wr_duty_i = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) ch_en_i = 3'($urandom);
      if ($urandom_range(0, 15) == 0) pol_i = 3'($urandom);
      adv();
      n_tests++;
      if ({pwm_o, period_o, pend_o} !== {m_pwm, m_per, m_pend}) begin
        n_fail++;
        $display("FAIL random cyc%0d pwm=%b period=%b pend=%b expected pwm=%b period=%b pend=%b",
                 k, pwm_o, period_o, pend_o, m_pwm, m_per, m_pend);
      end
    end
    rst_i   = 1'b0;
    wr_en_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_duty_apply();
    test_write_on_wrap();
    test_extremes_polarity();
    test_servo();
    test_invalid_freeze_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_multi_ch.md
Name: pwm_multi_ch

Overview:
- Parameterised N-channel PWM generator; successor to the single-prescaler, fixed three-output PWM block.
- Provides per-channel duty registers written through a simple write port, double-buffered and applied only at period boundaries (glitch-free).
- Supports per-channel enable and polarity, plus two modes: DIRECT (duty = counts high) and SERVO (duty mapped into a 1–2 ms-style window).
- Sits between a register/pin front end and the output pads of the user tile.

Parameters:
- NUM_CH, 3, number of PWM channels (1..16).
- CNT_W, 8, width of the duty value and of the period counter.
- PERIOD_TOP, 255, last value of the period counter; period = PERIOD_TOP+1 ticks.
- PRE_W, 32, prescaler counter width.
- DIV_DIRECT, 10416, prescaler terminal value in DIRECT mode (960 Hz-class at 10 MHz).
- DIV_SERVO, 200000, prescaler terminal value in SERVO mode (50 Hz-class at 10 MHz).
- SERVO_MIN, 13, SERVO threshold offset in period counts (5 % of 256).
- SERVO_SPAN, 13, SERVO threshold range in period counts.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- en_i  in  1  global run; low freezes prescaler and period counter
- mode_i  in  1  requested mode: 0 = DIRECT, 1 = SERVO
- wr_en_i  in  1  duty write strobe, one write per cycle
- wr_ch_i  in  $clog2(NUM_CH) (min 1)  target channel
- wr_duty_i  in  CNT_W  duty value
- ch_en_i  in  NUM_CH  per-channel enable
- pol_i  in  NUM_CH  per-channel polarity; 1 inverts the output
- pwm_o  out  NUM_CH  registered PWM outputs
- period_o  out  1  one-cycle pulse at each period wrap
- pend_o  out  NUM_CH  shadow duty written but not yet applied

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst_i.
- Reset values:
  - pwm_o, period_o and pend_o are 0.
  - Prescaler, period counter, shadow and active duties are 0.
  - Active mode is DIRECT.
- Prescaler:
  - When en_i=1, pre_cnt increments each cycle.
  - tick = en_i && (pre_cnt == div), where div = DIV_SERVO if the active mode is SERVO, else DIV_DIRECT.
  - On tick, pre_cnt returns to 0, so the tick interval is div+1 cycles.
- Period counter:
  - p_cnt increments on tick.
  - On tick with p_cnt == PERIOD_TOP, p_cnt goes to 0; this is the wrap event.
  - period_o is registered and high exactly one cycle after each wrap.
- Write port:
  - wr_en_i=1 with wr_ch_i < NUM_CH loads shadow[wr_ch_i] and sets pend_o[wr_ch_i] on the next edge.
  - wr_ch_i >= NUM_CH is ignored and no state changes.
  - Writing the same channel again before a wrap overwrites the shadow; the last write wins.
- Apply on wrap:
  - For every channel with pending set: active[i] <= shadow[i], and pend_o[i] is cleared.
  - mode_i is sampled into the active mode on the same edge.
  - If the mode changed, pre_cnt is also forced to 0 on that edge.
- Write coinciding with a wrap:
  - Apply uses the pre-edge shadow.
  - The new write lands in the shadow with pend_o set, and takes effect at the next wrap.
- Threshold per channel:
  - DIRECT: thr = active[i], zero-extended to CNT_W+1.
  - SERVO: thr = SERVO_MIN + ((active[i] * SERVO_SPAN) >> CNT_W); compute in CNT_W+PRE_W-safe width, with no truncation before the shift.
- Output:
  - pwm_o[i] <= ch_en_i[i] ? ((p_cnt < thr) ^ pol_i[i]) : pol_i[i].
  - One-cycle latency from p_cnt.
  - A disabled channel idles at its inactive level.
- Boundaries:
  - thr = 0 gives constant inactive level.
  - thr > PERIOD_TOP gives constant active level (100 %); no glitch at wrap.
  - ch_en_i and pol_i are not buffered and act with one-cycle latency.
- en_i=0: pre_cnt and p_cnt hold, and no wraps occur. pwm_o keeps tracking the comparison of the frozen p_cnt (static level). Writes are still accepted.
- rst_i asserted mid-period: on that edge, all state returns to reset values, including pending writes and the active mode.

Decomposition:
- Shared package pwm_pkg holds:
  - mode encodings MODE_DIRECT = 1'b0, MODE_SERVO = 1'b1;
  - the default divisors and SERVO constants;
  - a function computing the SERVO threshold.
- One sub-module, pwm_prescaler: pre_cnt, divisor select, tick, synchronous clear on mode change.
- Per-channel compare/shadow logic is generated inline in pwm_multi_ch with a generate loop.

Test Plan:
- Setup: DIV_DIRECT=3, DIV_SERVO=7, PERIOD_TOP=15, CNT_W=4.
- Reset/idle: hold rst_i 3 cycles, then en_i=1, no writes → pwm_o=0, pend_o=0, period_o pulses every 64 cycles.
- Duty apply at boundary: write ch1 duty 4 mid-period → pend_o[1]=1 until the wrap. In the next period pwm_o[1] is high for 16 cycles (4 ticks × 4) from one cycle after p_cnt=0, then low. No change is allowed before the wrap.
- Write on wrap edge: write ch0 duty 8 in the same cycle as the wrap → the current period uses the old duty 0, ch0 shows duty 8 from the following period, and pend_o[0] stays set across the wrap.
- Extremes and polarity: ch2 duty 0 → constant low; duty 15 with PERIOD_TOP=15 → high for 15 of 16 ticks; pol_i[2]=1 inverts both.
- SERVO switch:
  - With SERVO_MIN=2 and SERVO_SPAN=2, write duty 8 and set mode_i=1 → the change takes effect at the next wrap.
  - Ticks then occur every 8 cycles, and thr = 2 + (16 >> 4) = 3, so pwm_o is high for 24 cycles per period.
- Invalid channel, freeze and mid-operation reset:
  - wr_ch_i=3 with NUM_CH=3 → no pend_o change.
  - en_i=0 for 20 cycles → p_cnt frozen, no period_o.
  - rst_i mid-period → all outputs 0 next cycle and the mode returns to DIRECT.
